// File: rtl/log_event_collector.sv
// Severity-filtered log event sink: show-ahead FIFO with drop accounting and pop-handshake drain.
// Optional LOG_TIMESTAMP_EN stores a free-running cycle stamp with each entry.
module log_event_collector #(
    parameter int MSG_W = 16,
    parameter int DEPTH = 16,
    parameter int TS_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ev_valid,
    input  logic [1:0]               ev_sev,
    input  logic [MSG_W-1:0]         ev_msg,
    input  logic [1:0]               thr,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [1:0]               rd_sev,
    output logic [MSG_W-1:0]         rd_msg,
    output logic                     rd_ovf,
    output logic [TS_W-1:0]          rd_ts,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // WARN has an alias encoding; fold it so comparisons and storage see one value.
    function automatic logic [1:0] norm_sev(input logic [1:0] s);
        return s[1] ? 2'd2 : s;
    endfunction

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_next;
    logic             pending;
    logic             accept;
    logic             full;
    logic             pop;
    logic             wr;
    logic             drop;

    logic [1:0]       sev_mem [DEPTH];
    logic [MSG_W-1:0] msg_mem [DEPTH];
    logic             ovf_mem [DEPTH];

    assign accept = ev_valid && (norm_sev(ev_sev) >= norm_sev(thr));
    assign full   = (level == LW'(DEPTH));
    assign pop    = rd_en && rd_valid;
    // At full, a same-cycle pop frees the slot before the write lands.
    assign wr     = accept && (!full || pop);
    assign drop   = accept && full && !pop;

    always_comb begin
        level_next = level;
        if (wr && !pop)
            level_next = level + LW'(1);
        else if (pop && !wr)
            level_next = level - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
            pending  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            level    <= level_next;
            rd_valid <= (level_next != '0);
            if (wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (wr)
                pending <= 1'b0;
            else if (drop)
                pending <= 1'b1;
            if (drop && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Storage is plain RAM; emptiness gating on the outputs hides stale content.
    always_ff @(posedge clk) begin
        if (!rst && wr) begin
            sev_mem[wr_ptr] <= norm_sev(ev_sev);
            msg_mem[wr_ptr] <= ev_msg;
            ovf_mem[wr_ptr] <= pending;
        end
    end

    assign rd_sev = rd_valid ? sev_mem[rd_ptr] : 2'd0;
    assign rd_msg = rd_valid ? msg_mem[rd_ptr] : '0;
    assign rd_ovf = rd_valid ? ovf_mem[rd_ptr] : 1'b0;

`ifdef LOG_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] ts_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst)
            ts_cnt <= '0;
        else
            ts_cnt <= ts_cnt + TS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst && wr)
            ts_mem[wr_ptr] <= ts_cnt;
    end

    assign rd_ts = rd_valid ? ts_mem[rd_ptr] : '0;
`else
    assign rd_ts = '0;
`endif

endmodule

// File: tb/tb_log_event_collector.sv
// Randomized self-checking bench for log_event_collector against a queue-based reference model.
module tb_log_event_collector;

    localparam int MSG_W = 16;
    localparam int DEPTH = 16;
    localparam int TS_W  = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             ev_valid;
    logic [1:0]       ev_sev;
    logic [MSG_W-1:0] ev_msg;
    logic [1:0]       thr;
    logic             rd_en;
    logic             rd_valid;
    logic [1:0]       rd_sev;
    logic [MSG_W-1:0] rd_msg;
    logic             rd_ovf;
    logic [TS_W-1:0]  rd_ts;
    logic [4:0]       level;
    logic [7:0]       drop_cnt;

    always #5 clk = ~clk;

    log_event_collector #(.MSG_W(MSG_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_sev(ev_sev), .ev_msg(ev_msg),
        .thr(thr), .rd_en(rd_en), .rd_valid(rd_valid), .rd_sev(rd_sev), .rd_msg(rd_msg),
        .rd_ovf(rd_ovf), .rd_ts(rd_ts), .level(level), .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic [1:0]       sev;
        logic [MSG_W-1:0] msg;
        logic             ovf;
        logic [TS_W-1:0]  ts;
    } ent_t;

    ent_t        q[$];
    logic        m_pend;
    int          m_drops;
    logic [31:0] m_ts;
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic int sev_rank(input logic [1:0] s);
        return (s == 2'd3) ? 2 : int'(s);
    endfunction

    function automatic logic [TS_W-1:0] exp_ts(input logic [TS_W-1:0] t);
`ifdef LOG_TIMESTAMP_EN
        return t;
`else
        return '0;
`endif
    endfunction

    // One clock: drive inputs, let the edge happen, advance the model, settle at the falling edge.
    task automatic step(input logic v, input logic [1:0] s, input logic [MSG_W-1:0] m,
                        input logic r, input logic rs);
        logic acc;
        logic popped;
        ent_t e;
        ev_valid = v; ev_sev = s; ev_msg = m; rd_en = r; rst = rs;
        @(posedge clk);
        if (rs) begin
            q.delete(); m_pend = 1'b0; m_drops = 0; m_ts = '0;
        end else begin
            acc    = v && (sev_rank(s) >= sev_rank(thr));
            popped = r && (q.size() != 0);
            if (popped) void'(q.pop_front());
            if (acc) begin
                if (q.size() < DEPTH) begin
                    e.sev = 2'(sev_rank(s)); e.msg = m; e.ovf = m_pend; e.ts = m_ts;
                    q.push_back(e);
                    m_pend = 1'b0;
                end else begin
                    m_pend = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
            m_ts = m_ts + 1;
        end
        @(negedge clk);
        ev_valid = 1'b0; rd_en = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        thr = 2'd0;
        step(1'b1, 2'd2, 16'h1234, 1'b1, 1'b1);
        n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %0d want 0", rd_valid); end
        n_chk++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        n_chk++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
        n_chk++; if ({rd_sev, rd_msg, rd_ovf} !== '0) begin n_fail++; $display("FAIL reset_rd_fields: got %0h %0h %0b want 0", rd_sev, rd_msg, rd_ovf); end
        n_chk++; if (rd_ts !== '0) begin n_fail++; $display("FAIL reset_rd_ts: got %0d want 0", rd_ts); end
    endtask

    task automatic test_filter();
        thr = 2'd1;
        step(1'b1, 2'd0, 16'h0001, 1'b0, 1'b0);
        n_chk++; if (rd_valid !== 1'b0 || level !== 5'd0) begin n_fail++; $display("FAIL filter_debug_dropped: got valid=%0d level=%0d want 0/0", rd_valid, level); end
        step(1'b1, 2'd1, 16'h0002, 1'b0, 1'b0);
        n_chk++; if (rd_valid !== 1'b1 || level !== 5'd1) begin n_fail++; $display("FAIL filter_info_kept: got valid=%0d level=%0d want 1/1", rd_valid, level); end
        n_chk++; if (rd_msg !== 16'h0002 || rd_sev !== 2'd1 || rd_ovf !== 1'b0) begin n_fail++; $display("FAIL filter_head: got msg=%0h sev=%0d ovf=%0d want 2/1/0", rd_msg, rd_sev, rd_ovf); end
        n_chk++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL filter_not_drop: got %0d want 0", drop_cnt); end
        step(1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
        n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL filter_drain: got %0d want 0", rd_valid); end
    endtask

    task automatic test_empty_pop();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
            n_chk++; if (rd_valid !== 1'b0 || level !== 5'd0 || drop_cnt !== 8'd0) begin
                n_fail++; $display("FAIL empty_pop: got valid=%0d level=%0d drops=%0d want 0/0/0", rd_valid, level, drop_cnt);
            end
        end
    endtask

    task automatic test_overflow();
        thr = 2'd0;
        for (int i = 1; i <= 18; i++) step(1'b1, 2'($urandom_range(0, 3)), 16'(i), 1'b0, 1'b0);
        n_chk++; if (level !== 5'd16) begin n_fail++; $display("FAIL ovf_level: got %0d want 16", level); end
        n_chk++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL ovf_drop_cnt: got %0d want 2", drop_cnt); end
        for (int i = 1; i <= 16; i++) begin
            n_chk++; if (rd_valid !== 1'b1 || rd_msg !== 16'(i) || rd_ovf !== 1'b0) begin
                n_fail++; $display("FAIL ovf_drain: got valid=%0d msg=%0d ovf=%0d want 1/%0d/0", rd_valid, rd_msg, rd_ovf, i);
            end
            step(1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
        end
        n_chk++; if (level !== 5'd0) begin n_fail++; $display("FAIL ovf_empty: got %0d want 0", level); end
        step(1'b1, 2'd1, 16'd19, 1'b0, 1'b0);
        n_chk++; if (rd_msg !== 16'd19 || rd_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got msg=%0d ovf=%0d want 19/1", rd_msg, rd_ovf); end
        step(1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic test_full_pop_write();
        thr = 2'd0;
        for (int i = 0; i < 16; i++) step(1'b1, 2'd0, 16'(100 + i), 1'b0, 1'b0);
        step(1'b1, 2'd3, 16'hAAAA, 1'b1, 1'b0);
        n_chk++; if (level !== 5'd16) begin n_fail++; $display("FAIL fullpw_level: got %0d want 16", level); end
        n_chk++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL fullpw_drop_cnt: got %0d want 2", drop_cnt); end
        n_chk++; if (rd_msg !== 16'd101) begin n_fail++; $display("FAIL fullpw_head: got %0d want 101", rd_msg); end
        for (int i = 0; i < 15; i++) step(1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
        n_chk++; if (rd_msg !== 16'hAAAA || rd_sev !== 2'd2 || rd_ovf !== 1'b0 || level !== 5'd1) begin
            n_fail++; $display("FAIL fullpw_tail: got msg=%0h sev=%0d ovf=%0d level=%0d want aaaa/2/0/1", rd_msg, rd_sev, rd_ovf, level);
        end
        step(1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic test_saturate_and_reset();
        thr = 2'd2;
        for (int i = 0; i < 316; i++) step(1'b1, 2'd2, 16'(i), 1'b0, 1'b0);
        n_chk++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_drop_cnt: got %0d want 255", drop_cnt); end
        n_chk++; if (level !== 5'd16 || rd_msg !== 16'd0) begin n_fail++; $display("FAIL sat_no_overwrite: got level=%0d head=%0d want 16/0", level, rd_msg); end
        step(1'b1, 2'd2, 16'hBEEF, 1'b1, 1'b1);
        n_chk++; if (level !== 5'd0 || rd_valid !== 1'b0 || drop_cnt !== 8'd0) begin
            n_fail++; $display("FAIL midrst: got level=%0d valid=%0d drops=%0d want 0/0/0", level, rd_valid, drop_cnt);
        end
    endtask

    task automatic test_timestamp();
        logic [TS_W-1:0] t1;
        logic [TS_W-1:0] t2;
        thr = 2'd0;
        step(1'b0, 2'd0, 16'h0, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) step((c == 5 || c == 9), 2'd1, 16'(c), 1'b0, 1'b0);
`ifdef LOG_TIMESTAMP_EN
        t1 = 32'd5; t2 = 32'd9;
`else
        t1 = '0; t2 = '0;
`endif
        n_chk++; if (rd_ts !== t1 || rd_msg !== 16'd5) begin n_fail++; $display("FAIL ts_first: got ts=%0d msg=%0d want %0d/5", rd_ts, rd_msg, t1); end
        step(1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
        n_chk++; if (rd_ts !== t2 || rd_msg !== 16'd9) begin n_fail++; $display("FAIL ts_second: got ts=%0d msg=%0d want %0d/9", rd_ts, rd_msg, t2); end
        step(1'b0, 2'd0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [1:0] s;
        logic       v;
        logic       r;
        logic       rs;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 31) == 0) thr = 2'($urandom_range(0, 3));
            v  = ($urandom_range(0, 99) < 70);
            // Alternate read-heavy and write-heavy phases so full and empty both occur.
            r  = ((c / 100) % 2 == 0) ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 85);
            rs = ($urandom_range(0, 499) == 0);
            s  = 2'($urandom_range(0, 3));
            step(v, s, 16'($urandom), r, rs);
            n_chk++; if (rd_valid !== (q.size() != 0) || level !== 5'(q.size())) begin
                n_fail++; $display("FAIL rand_occupancy c=%0d: got valid=%0d level=%0d want %0d/%0d", c, rd_valid, level, q.size() != 0, q.size());
            end
            n_chk++; if (drop_cnt !== 8'(m_drops)) begin n_fail++; $display("FAIL rand_drop_cnt c=%0d: got %0d want %0d", c, drop_cnt, m_drops); end
            if (q.size() != 0) begin
                n_chk++; if (rd_msg !== q[0].msg || rd_sev !== q[0].sev || rd_ovf !== q[0].ovf || rd_ts !== exp_ts(q[0].ts)) begin
                    n_fail++; $display("FAIL rand_head c=%0d: got msg=%0h sev=%0d ovf=%0d ts=%0d want %0h/%0d/%0d/%0d",
                                       c, rd_msg, rd_sev, rd_ovf, rd_ts, q[0].msg, q[0].sev, q[0].ovf, exp_ts(q[0].ts));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; ev_valid = 1'b0; ev_sev = 2'd0; ev_msg = '0; thr = 2'd0; rd_en = 1'b0;
        m_pend = 1'b0; m_drops = 0; m_ts = '0;
        @(negedge clk);
        test_reset();
        test_filter();
        test_empty_pop();
        test_overflow();
        test_full_pop_write();
        test_saturate_and_reset();
        test_timestamp();
        step(1'b0, 2'd0, 16'h0, 1'b0, 1'b1);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
